// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and request legality check for the LSU memory port.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Byte-enable patterns before shifting to the addressed lane.
   localparam logic [3:0] BE_B = 4'b0001;
   localparam logic [3:0] BE_H = 4'b0011;
   localparam logic [3:0] BE_W = 4'b1111;

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StCapture,
      StResp
   } lsu_state_e;

   // Flags an unsupported funct3, an unsigned store, or a misaligned half/word access.
   function automatic logic req_illegal(input logic we, input logic [2:0] funct3,
                                        input logic [1:0] offset);
      logic bad;
      case (funct3)
         F3_B:    bad = 1'b0;
         F3_H:    bad = offset[0];
         F3_W:    bad = (offset != 2'b00);
         F3_BU:   bad = we;
         F3_HU:   bad = we | offset[0];
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half of a memory word and sign- or zero-extends it.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] dout_i,
   input  logic [1:0]  offset_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane selection followed by extension per funct3.
   always_comb begin
      byte_sel = dout_i[8*offset_i +: 8];
      half_sel = offset_i[1] ? dout_i[31:16] : dout_i[15:0];
      case (funct3_i)
         F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   data_o = {24'h0, byte_sel};
         F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
         F3_HU:   data_o = {16'h0, half_sel};
         F3_W:    data_o = dout_i;
         default: data_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/lsu_mem_port.sv
// Single-outstanding RV32I load/store initiator for a byte-enabled synchronous-read memory.
module lsu_mem_port
   import lsu_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 12
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [3:0]  mem_we,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_din,
   input  logic [31:0] mem_dout
);

   lsu_state_e  state_q, state_d;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        err_q;
   logic [31:0] rdata_q;
   logic [31:0] align_data;
   logic        accept;

   assign accept = (state_q == StIdle) && req_valid;

   lsu_load_align u_align (
      .dout_i   (mem_dout),
      .offset_i (addr_q[1:0]),
      .funct3_i (f3_q),
      .data_o   (align_data)
   );

   // Next-state logic: errors skip the memory, stores skip the capture cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:    if (req_valid) begin
                       state_d = req_illegal(req_we, req_funct3, req_addr[1:0]) ?
                                 StResp : StAccess;
                    end
         StAccess:  state_d = we_q ? StResp : StCapture;
         StCapture: state_d = StResp;
         StResp:    state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // State and request registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= StIdle;
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         err_q   <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            err_q   <= req_illegal(req_we, req_funct3, req_addr[1:0]);
            rdata_q <= 32'h0;
         end else if (state_q == StCapture) begin
            rdata_q <= align_data;
         end
      end
   end

   // Handshake, response and memory-side outputs; rstn gates anything with side effects.
   always_comb begin
      req_ready  = rstn && (state_q == StIdle);
      resp_valid = rstn && (state_q == StResp);
      resp_err   = resp_valid && err_q;
      resp_rdata = rdata_q;
      mem_addr   = {addr_q[31:DEPTH_LOG2+2], addr_q[DEPTH_LOG2+1:2]};
      case (f3_q)
         F3_B:    mem_din = {4{wdata_q[7:0]}};
         F3_H:    mem_din = {2{wdata_q[15:0]}};
         default: mem_din = wdata_q;
      endcase
      mem_we = 4'b0000;
      if (rstn && (state_q == StAccess) && we_q) begin
         case (f3_q)
            F3_B:    mem_we = BE_B << addr_q[1:0];
            F3_H:    mem_we = BE_H << addr_q[1:0];
            F3_W:    mem_we = BE_W;
            default: mem_we = 4'b0000;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a behavioural byte-enabled synchronous memory.
module tb_lsu_mem_port;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [3:0]  mem_we;
   logic [29:0] mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] mem [0:4095];

   always #5 clk = ~clk;

   lsu_mem_port #(.DEPTH_LOG2(12)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .mem_dout   (mem_dout)
   );

   // Memory model: per-byte writes, registered read of the old word.
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (mem_we[b]) mem[mem_addr[11:0]][8*b +: 8] <= mem_din[8*b +: 8];
      end
      mem_dout <= mem[mem_addr[11:0]];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issues one request from a negedge and follows it to its response.
   task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, output int lat, output logic [31:0] rd,
                      output logic er, output logic [3:0] we1, output logic [29:0] a1,
                      output logic [31:0] d1, output logic we_seen);
      int n;
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) check("accept_timeout", {31'h0, req_ready}, 32'h1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0; rd = 32'h0; er = 1'b0; we_seen = 1'b0; we1 = 4'h0; a1 = 30'h0; d1 = 32'h0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 1) begin
            we1 = mem_we; a1 = mem_addr; d1 = mem_din;
         end
         if (mem_we != 4'h0) we_seen = 1'b1;
         if (resp_valid) begin
            lat = c; rd = resp_rdata; er = resp_err;
            break;
         end
      end
   endtask

   int          lat;
   logic [31:0] rd;
   logic        er;
   logic [3:0]  we1;
   logic [29:0] a1;
   logic [31:0] d1;
   logic        wes;
   logic        seen;

   logic        b_we [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   logic [31:0] b_wd [6] = '{32'h1111_0001, 32'h0, 32'h2222_0002, 32'h0, 32'h3333_0003, 32'h0};
   logic [31:0] b_rd [6] = '{32'h0, 32'h1111_0001, 32'h0, 32'h2222_0002, 32'h0, 32'h3333_0003};
   int          acc, rsp, last_acc;
   logic        rdy;

   initial begin
      rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'h0; req_wdata = 32'h0;
      repeat (3) @(negedge clk);
      check("rst_ready_low", {31'h0, req_ready}, 32'h0);
      check("rst_mem_we", {28'h0, mem_we}, 32'h0);
      check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      rstn = 1'b1;
      @(negedge clk);
      check("rst_ready_high", {31'h0, req_ready}, 32'h1);
      check("rst_mem_addr", {2'b0, mem_addr}, 32'h0);
      check("rst_mem_din", mem_din, 32'h0);
      check("rst_rdata", resp_rdata, 32'h0);
      check("rst_err", {31'h0, resp_err}, 32'h0);

      // SW 0x10 / LW 0x10
      run(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rd, er, we1, a1, d1, wes);
      check("sw_we", {28'h0, we1}, 32'hF);
      check("sw_addr", {2'b0, a1}, 32'h4);
      check("sw_din", d1, 32'hDEADBEEF);
      check("sw_lat", lat, 2);
      check("sw_rdata", rd, 32'h0);
      run(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er, we1, a1, d1, wes);
      check("lw_lat", lat, 3);
      check("lw_rdata", rd, 32'hDEADBEEF);
      check("lw_err", {31'h0, er}, 32'h0);

      // SB 0x13 then byte loads and word readback
      run(1'b1, 3'b000, 32'h13, 32'h000000A5, lat, rd, er, we1, a1, d1, wes);
      check("sb_we", {28'h0, we1}, 32'h8);
      check("sb_din", d1, 32'hA5A5A5A5);
      run(1'b0, 3'b000, 32'h13, 32'h0, lat, rd, er, we1, a1, d1, wes);
      check("lb_rdata", rd, 32'hFFFFFFA5);
      run(1'b0, 3'b100, 32'h13, 32'h0, lat, rd, er, we1, a1, d1, wes);
      check("lbu_rdata", rd, 32'h000000A5);
      run(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er, we1, a1, d1, wes);
      check("lw_after_sb", rd, 32'hA5ADBEEF);

      // SH 0x12 then half loads
      run(1'b1, 3'b001, 32'h12, 32'h00008001, lat, rd, er, we1, a1, d1, wes);
      check("sh_we", {28'h0, we1}, 32'hC);
      check("sh_din", d1, 32'h80018001);
      run(1'b0, 3'b001, 32'h12, 32'h0, lat, rd, er, we1, a1, d1, wes);
      check("lh_rdata", rd, 32'hFFFF8001);
      run(1'b0, 3'b101, 32'h12, 32'h0, lat, rd, er, we1, a1, d1, wes);
      check("lhu_rdata", rd, 32'h00008001);
      run(1'b0, 3'b000, 32'h10, 32'h0, lat, rd, er, we1, a1, d1, wes);
      check("lb_lane0", rd, 32'hFFFFFFEF);

      // Error cases
      run(1'b0, 3'b010, 32'h6, 32'h0, lat, rd, er, we1, a1, d1, wes);
      check("lw_mis_lat", lat, 1);
      check("lw_mis_err", {31'h0, er}, 32'h1);
      check("lw_mis_rdata", rd, 32'h0);
      check("lw_mis_we", {31'h0, wes}, 32'h0);
      run(1'b1, 3'b001, 32'h5, 32'hFFFF, lat, rd, er, we1, a1, d1, wes);
      check("sh_mis_lat", lat, 1);
      check("sh_mis_err", {31'h0, er}, 32'h1);
      check("sh_mis_we", {31'h0, wes}, 32'h0);
      run(1'b1, 3'b100, 32'h10, 32'h0, lat, rd, er, we1, a1, d1, wes);
      check("sbu_err", {31'h0, er}, 32'h1);
      check("sbu_we", {31'h0, wes}, 32'h0);
      run(1'b0, 3'b011, 32'h10, 32'h0, lat, rd, er, we1, a1, d1, wes);
      check("f3_011_err", {31'h0, er}, 32'h1);
      run(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er, we1, a1, d1, wes);
      check("lw_after_errs", rd, 32'h8001BEEF);

      // Reset during ACCESS of a store
      run(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, lat, rd, er, we1, a1, d1, wes);
      check("sw20_lat", lat, 2);
      @(negedge clk);
      req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h12345678;
      req_valid = 1'b1;
      check("pre_abort_ready", {31'h0, req_ready}, 32'h1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      rstn = 1'b0;
      @(negedge clk);
      check("abort_we", {28'h0, mem_we}, 32'h0);
      check("abort_ready", {31'h0, req_ready}, 32'h0);
      @(posedge clk);
      #1 rstn = 1'b1;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (resp_valid) seen = 1'b1;
      end
      check("abort_no_resp", {31'h0, seen}, 32'h0);
      run(1'b0, 3'b010, 32'h20, 32'h0, lat, rd, er, we1, a1, d1, wes);
      check("abort_prior", rd, 32'hCAFEF00D);

      // Back-to-back with req_valid held high
      req_we = b_we[0]; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = b_wd[0];
      req_valid = 1'b1;
      acc = 0; rsp = 0; last_acc = 0;
      for (int cyc = 0; cyc < 60 && rsp < 6; cyc++) begin
         @(negedge clk);
         rdy = req_ready;
         if (resp_valid) begin
            check("b2b_rdata", resp_rdata, b_rd[rsp]);
            check("b2b_ready_in_resp", {31'h0, req_ready}, 32'h0);
            rsp++;
         end
         @(posedge clk);
         if (rdy && acc < 6) begin
            if (acc > 0) check("b2b_gap", cyc - last_acc, b_we[acc-1] ? 3 : 4);
            last_acc = cyc;
            acc++;
            #1;
            if (acc < 6) begin
               req_we = b_we[acc]; req_wdata = b_wd[acc];
            end else begin
               req_valid = 1'b0;
            end
         end
      end
      req_valid = 1'b0;
      check("b2b_accepts", acc, 6);
      check("b2b_resps", rsp, 6);
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (resp_valid) seen = 1'b1;
      end
      check("b2b_no_extra_resp", {31'h0, seen}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store initiator sitting between the CPU pipeline's memory stage and the byte-enabled, single-port data memory (4096 words, synchronous read, one-cycle registered `dout`, per-byte write enables). It accepts one RV32I load/store request at a time over a valid/ready handshake, generates the word address, byte enables and lane-shifted write data, waits out the memory read latency, and returns aligned, sign- or zero-extended load data or an error flag.

## Interface
- `DEPTH_LOG2`, 12: word-address bits used by the memory; `mem_addr` upper bits pass through unchanged.
- `clk` in 1: single clock, all state updates on posedge.
- `rstn` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, LSB-aligned.
- `resp_valid` out 1: one-cycle completion pulse; no backpressure.
- `resp_rdata` out 32: formatted load data; 0 for stores and errors.
- `resp_err` out 1: misaligned or illegal funct3; qualified by `resp_valid`.
- `mem_we` out 4: byte write enables to memory.
- `mem_addr` out 30: word address `[31:2]`.
- `mem_din` out 32: lane-shifted write data.
- `mem_dout` in 32: memory read word; valid the cycle after the address was presented.

## Operation
- States: IDLE, ACCESS, CAPTURE, RESP.
- IDLE: `req_ready`=1. On `req_valid`: latch `we`, `funct3`, `addr`, `wdata`. Next state: RESP with error set if illegal, otherwise ACCESS.
- Illegal: funct3 ∉ {000, 001, 010, 100, 101}. Store with 100 or 101 is illegal. H with `addr[0]`=1 is misaligned. W with `addr[1:0]`≠0 is misaligned.
- ACCESS: drive `mem_addr` = latched `addr[31:2]`.
  - Stores: `mem_we` = 0001 << `addr[1:0]` (B), 0011 << `addr[1:0]` (H), 1111 (W). `mem_din` = `wdata` replicated per lane (B: {4{b}}, H: {2{h}}, W: w).
  - Store → RESP. Load → CAPTURE.
- CAPTURE: select byte/half from `mem_dout` using `addr[1:0]`, extend per funct3, register into `resp_rdata`. → RESP.
- RESP: `resp_valid`=1 for exactly one cycle. → IDLE.
- `mem_we`=0000 in every state except ACCESS-with-store. It is also forced to 0000 combinationally whenever `rstn`=0.
- `mem_addr` and `mem_din` hold latched values in all states. The memory reads continuously, so address stability matters only in ACCESS.
- No read-modify-write: sub-word stores rely solely on byte enables.

## Timing
- Accept at edge 0 (T0). Store: memory written at end of T1, `resp_valid` in T2. Load: data sampled in T2, `resp_valid` with data in T3. Error: `resp_valid`+`resp_err` in T1, no memory access.
- Back-to-back throughput: one request per 3 (store), 4 (load) or 2 (error) cycles. `req_ready` rises the cycle after RESP.
- Reset values: state IDLE, `req_ready`=1 after reset released (0 while `rstn`=0), `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0.
- Reset mid-operation: abort to IDLE with no response. A store in ACCESS while `rstn`=0 performs no write.
- `req_valid` while not ready is ignored. The request source must hold it until accepted.

## Structure
- Package `lsu_pkg`: funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`), state encoding, byte-enable helper constants.
- Sub-module `lsu_load_align`: combinational `mem_dout`/offset/funct3 → 32-bit extended data, reused by later pipeline bypass logic.

## Test plan
- SW addr 0x0000_0010, data 0xDEADBEEF. In T1 expect `mem_we`=1111, `mem_addr`=0x4, `mem_din`=0xDEADBEEF. Then LW 0x10 gives `resp_rdata`=0xDEADBEEF in T3.
- SB 0x13 data 0x000000A5. Expect `mem_we`=1000, `mem_din`=0xA5A5A5A5. Then LB 0x13 → 0xFFFFFFA5 and LBU 0x13 → 0x000000A5. LW 0x10 → 0xA5ADBEEF.
- SH 0x12 data 0x8001, then LH 0x12 → 0xFFFF8001, LHU 0x12 → 0x00008001.
- LW 0x0000_0006 → `resp_err`=1 in T1, `resp_rdata`=0, `mem_we` never nonzero. SH 0x5 behaves the same. A store with funct3=100 → error.
- Assert `rstn`=0 during ACCESS of SW 0x20 data 0x12345678. Expect `mem_we`=0, no `resp_valid`, and a later LW 0x20 returns the prior contents.
- Hold `req_valid`=1 continuously with alternating load/store. Verify `req_ready` is high only in IDLE, exactly one `resp_valid` per accepted request, and gaps of 3/4 cycles.
